instruction_prefetch_buffer: RTL and testbench

//  Fetch stage between memory_controller and the processor decode pipeline. Issues word-addressed

---
 rtl/instruction_prefetch_buffer_pkg.sv | 26 ++
 rtl/instruction_prefetch_buffer_sync_fifo.sv | 72 +++++++
 rtl/instruction_prefetch_buffer.sv | 114 +++++++++++
 tb/tb_instruction_prefetch_buffer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_prefetch_buffer_pkg.sv
// Shared encodings for the instruction prefetch buffer: bus transfer types,
// fetch FSM states, queue entry layout and decode-side substitution constants.
package instruction_prefetch_buffer_pkg;

   localparam logic [1:0] TRANS_IDLE = 2'b00;
   localparam logic [1:0] TRANS_NSEQ = 2'b10;
   localparam logic [1:0] TRANS_SEQ  = 2'b11;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_e;

   // Decode substitutes an always-executed NOP for an aborted fetch.
   localparam logic [3:0]  COND_AL   = 4'hE;
   localparam logic [31:0] INSTR_NOP = 32'hE1A0_0000;

   typedef struct packed {
      logic        abort;
      logic [31:0] pc;
      logic [31:0] data;
   } fetch_entry_t;

   localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/instruction_prefetch_buffer_sync_fifo.sv
// Synchronous FIFO with synchronous clear; pop on empty is ignored and the
// producer guarantees it never pushes into a full queue.
module sync_fifo #(
   parameter int unsigned WIDTH = 65,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       n_reset,
   input  logic                       clear_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop, full;

   assign full    = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !clear_i;
   assign do_pop  = pop_i && !clear_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Pointer and occupancy next-state; clear dominates push/pop.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      count_d = count_q + CW'(1);
         else if (do_pop && !do_push) count_d = count_q - CW'(1);
      end
   end

   // Control registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are only observed through valid entries.
   always_ff @(posedge clk) begin
      if (n_reset && do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   push_on_full_a : assert property (@(posedge clk) disable iff (!n_reset)
      !(do_push && full && !do_pop));

endmodule

// File: rtl/instruction_prefetch_buffer.sv
// Fetch stage: issues word reads to the memory controller while the queue has
// credit, queues returned words with their PC and abort flag, and hands them to
// decode over valid/ready. Flush redirects fetch and discards everything queued.
module instruction_prefetch_buffer
   import instruction_prefetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter logic [31:0] RESET_ADDR = '0
) (
   input  logic        clk,
   input  logic        n_reset,
   output logic [31:0] addr,
   output logic        write,
   output logic [1:0]  trans,
   input  logic [31:0] rdata,
   input  logic        abort,
   input  logic        flush,
   input  logic [31:0] flush_addr,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_abort,
   output logic        instr_valid,
   input  logic        instr_ready
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   fetch_state_e state_q, state_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  pend_pc_q, pend_pc_d;
   logic         resp_pending_q, resp_pending_d;
   logic         seq_q, seq_d;

   logic         issue, push, pop, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [CW:0]  occupancy;
   fetch_entry_t wr_entry, head;

   // Credit counts the in-flight read as well as stored entries, so a
   // returning word always has a free slot.
   assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, resp_pending_q};
   assign push      = resp_pending_q && !flush;
   assign pop       = instr_valid && instr_ready && !flush;

   assign wr_entry.abort = abort;
   assign wr_entry.pc    = pend_pc_q;
   assign wr_entry.data  = rdata;

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .n_reset (n_reset),
      .clear_i (flush),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (wr_entry),
      .rdata_o (head),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign addr        = fetch_pc_q;
   assign write       = 1'b0;
   assign instr_valid = !fifo_empty;
   assign instr       = instr_valid ? head.data : '0;
   assign instr_pc    = instr_valid ? head.pc   : '0;
   assign instr_abort = instr_valid && head.abort;

   // Issue decision, fetch FSM next state and request bookkeeping.
   always_comb begin
      state_d        = state_q;
      fetch_pc_d     = fetch_pc_q;
      pend_pc_d      = pend_pc_q;
      resp_pending_d = 1'b0;
      seq_d          = seq_q;
      issue          = (state_q == ST_RUN) && !flush && (occupancy < (CW+1)'(DEPTH));
      trans          = TRANS_IDLE;
      if (issue) trans = seq_q ? TRANS_SEQ : TRANS_NSEQ;

      if (flush) begin
         state_d    = ST_RUN;
         fetch_pc_d = flush_addr;
         seq_d      = 1'b0;
      end else begin
         if (issue) begin
            fetch_pc_d     = fetch_pc_q + 32'd1;
            pend_pc_d      = fetch_pc_q;
            resp_pending_d = 1'b1;
            seq_d          = 1'b1;
         end
         if (push && abort) state_d = ST_HALT;
      end
   end

   // Fetch state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q        <= ST_RUN;
         fetch_pc_q     <= RESET_ADDR;
         pend_pc_q      <= '0;
         resp_pending_q <= 1'b0;
         seq_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         fetch_pc_q     <= fetch_pc_d;
         pend_pc_q      <= pend_pc_d;
         resp_pending_q <= resp_pending_d;
         seq_q          <= seq_d;
      end
   end

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Bench for instruction_prefetch_buffer: a memory model answers reads one cycle
// later with 0x1000+address, and a queue-based reference model predicts every
// output each cycle under directed and randomized stimulus.
module tb_instruction_prefetch_buffer;

   localparam int unsigned DEPTH      = 4;
   localparam logic [31:0] RESET_ADDR = 32'h0;

   logic        clk = 1'b0;
   logic        n_reset;
   logic [31:0] addr;
   logic        write;
   logic [1:0]  trans;
   logic [31:0] rdata;
   logic        abort;
   logic        flush;
   logic [31:0] flush_addr;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_abort;
   logic        instr_valid;
   logic        instr_ready;

   always #5 clk = ~clk;

   instruction_prefetch_buffer #(
      .DEPTH      (DEPTH),
      .RESET_ADDR (RESET_ADDR)
   ) dut (
      .clk         (clk),
      .n_reset     (n_reset),
      .addr        (addr),
      .write       (write),
      .trans       (trans),
      .rdata       (rdata),
      .abort       (abort),
      .flush       (flush),
      .flush_addr  (flush_addr),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_abort (instr_abort),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready)
   );

   // Memory: responds in the cycle after a request; garbage otherwise.
   logic        req_v;
   logic [31:0] req_addr;
   logic [31:0] junk_data;
   logic        junk_abort;
   logic        ab_single, ab_rand;
   logic [31:0] ab_addr;

   function automatic logic abort_for(input logic [31:0] a);
      return (ab_single && a == ab_addr) || (ab_rand && a[3:0] == 4'hB);
   endfunction

   assign rdata = req_v ? 32'h1000 + req_addr : junk_data;
   assign abort = req_v ? ((ab_single && req_addr == ab_addr) ||
                           (ab_rand && req_addr[3:0] == 4'hB)) : junk_abort;

   // Reference model: queue of fetched words plus fetch bookkeeping.
   typedef struct {
      logic        ab;
      logic [31:0] pc;
      logic [31:0] data;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc, m_pend_pc;
   bit          m_pend, m_seq, m_halt;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset(input logic [31:0] pc);
      mq.delete();
      m_pc   = pc;
      m_pend = 0;
      m_seq  = 0;
      m_halt = 0;
   endtask

   // One clock: check outputs at negedge, advance model, then drive memory.
   task automatic tick();
      bit          e_v, issue, nreq_v, ab;
      logic [1:0]  e_tr;
      logic [31:0] nreq_addr;
      ent_t        e;
      @(negedge clk);
      e_v   = mq.size() != 0;
      issue = !m_halt && !flush && (mq.size() + int'(m_pend)) < int'(DEPTH);
      e_tr  = issue ? (m_seq ? 2'b11 : 2'b10) : 2'b00;
      check_eq("trans", {30'b0, trans}, {30'b0, e_tr});
      check_eq("addr", addr, m_pc);
      check_eq("write", {31'b0, write}, 32'd0);
      check_eq("instr_valid", {31'b0, instr_valid}, {31'b0, e_v});
      check_eq("instr", instr, e_v ? mq[0].data : 32'h0);
      check_eq("instr_pc", instr_pc, e_v ? mq[0].pc : 32'h0);
      check_eq("instr_abort", {31'b0, instr_abort}, {31'b0, e_v ? mq[0].ab : 1'b0});
      nreq_v    = (trans != 2'b00);
      nreq_addr = addr;
      if (!n_reset) begin
         model_reset(RESET_ADDR);
      end else if (flush) begin
         model_reset(flush_addr);
      end else begin
         if (e_v && instr_ready) void'(mq.pop_front());
         if (m_pend) begin
            ab     = abort_for(m_pend_pc);
            e.ab   = ab;
            e.pc   = m_pend_pc;
            e.data = 32'h1000 + m_pend_pc;
            mq.push_back(e);
            if (ab) m_halt = 1;
         end
         if (issue) begin
            m_pend_pc = m_pc;
            m_pc      = m_pc + 32'd1;
            m_pend    = 1;
            m_seq     = 1;
         end else begin
            m_pend = 0;
         end
      end
      @(posedge clk);
      #1;
      req_v      = nreq_v;
      req_addr   = nreq_addr;
      junk_data  = $urandom;
      junk_abort = 1'($urandom_range(0, 1));
   endtask

   task automatic run(input int n, input logic rdy);
      for (int i = 0; i < n; i++) begin
         instr_ready = rdy;
         tick();
      end
   endtask

   task automatic do_flush(input logic [31:0] fa);
      flush      = 1'b1;
      flush_addr = fa;
      tick();
      flush      = 1'b0;
      flush_addr = $urandom;
   endtask

   initial begin
      n_reset     = 1'b0;
      flush       = 1'b0;
      flush_addr  = 32'h0;
      instr_ready = 1'b0;
      req_v       = 1'b0;
      req_addr    = 32'h0;
      junk_data   = 32'hDEAD_BEEF;
      junk_abort  = 1'b1;
      ab_single   = 1'b0;
      ab_rand     = 1'b0;
      ab_addr     = 32'h0;
      model_reset(RESET_ADDR);

      // Reset, then streaming with an always-ready consumer.
      run(2, 1'b0);
      n_reset = 1'b1;
      run(16, 1'b1);

      // Back-pressure: queue fills to DEPTH, then drains.
      run(10, 1'b0);
      run(10, 1'b1);

      // Flush with entries queued and a read in flight.
      run(6, 1'b0);
      instr_ready = 1'b0;
      do_flush(32'h80);
      run(8, 1'b1);

      // Back-to-back flushes: the last address wins.
      run(3, 1'b0);
      flush = 1'b1; flush_addr = 32'h40; tick();
      flush_addr = 32'h60; tick();
      flush = 1'b0;
      run(6, 1'b1);

      // Abort on address 5 halts fetch; queue drains; flush resumes.
      do_flush(32'h0);
      ab_single = 1'b1;
      ab_addr   = 32'h5;
      run(12, 1'b0);
      run(12, 1'b1);
      do_flush(32'h20);
      ab_single = 1'b0;
      run(8, 1'b1);

      // Reset mid-stream with entries queued and a read in flight.
      run(3, 1'b0);
      n_reset = 1'b0;
      tick();
      n_reset = 1'b1;
      run(6, 1'b1);

      // Address wrap across 2^32.
      do_flush(32'hFFFF_FFFE);
      run(10, 1'b1);

      // Randomized traffic with occasional aborts, flushes and resets.
      ab_rand = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         instr_ready = ($urandom_range(0, 9) < 7);
         flush       = ($urandom_range(0, 39) == 0);
         flush_addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3) : $urandom;
         n_reset     = !($urandom_range(0, 199) == 0);
         tick();
      end
      n_reset = 1'b1;
      flush   = 1'b0;
      run(10, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
